bin16_to_bcd_converter: RTL and testbench
=========================================

# bin16_to_bcd_converter

Sequential binary-to-BCD converter placed directly upstream of the four-digit seven-segment display controller. It takes the 16-bit unsigned value to be shown (DSP product or block-RAM word) and returns four packed BCD digits plus an overflow flag. The display controller then selects one nibble per active anode instead of running divide/modulo logic. Conversion uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, under a start/busy/done handshake.

## Interface
- BIN_WIDTH, 16, width of the binary input; legal range 4..16; the internal BCD scratch is always 5 digits (20 bits).
- clock_100Mhz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, regardless of the clock.
- start  input  1  conversion request; sampled on the rising edge; acted on only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (SHIFT or FIN state).
- done  output  1  single-cycle pulse marking new bcd_out/overflow.
- bcd_out  output  16  [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- overflow  output  1  1 when the captured value is above 9999 (ten-thousands digit nonzero).

## Operation
- Reset state (reset=0): state IDLE, busy=0, done=0, bcd_out=16'h0000, overflow=0, shift register=0, scratch=0, bit counter=0.
- IDLE:
  - On an edge with start=1: load shift register with bin_in, clear the 20-bit scratch, clear the counter, set busy=1, go to SHIFT.
  - With start=0: hold all state.
  - done is 0 in every state except the cycle after FIN.
- SHIFT: each edge performs one iteration:
  - Every scratch nibble of 5 or more gets 3 added. All five nibbles are corrected in parallel and combinationally.
  - {scratch, shift} shifts left by 1.
  - Counter increments.
  - After iteration BIN_WIDTH (counter reaches BIN_WIDTH-1), go to FIN.
- FIN: one edge:
  - bcd_out <= scratch[15:0]
  - overflow <= (scratch[19:16] != 0)
  - done <= 1, busy <= 0
  - go to IDLE
- done self-clears on the following edge.
- bcd_out and overflow hold their values until the next FIN. They do not change while busy.
- When overflow=1, bcd_out still carries the low four decimal digits (value mod 10000).
- start while busy=1 is ignored; it is neither queued nor an error.
- Changes on bin_in after the capture edge have no effect on the conversion in progress.
- Arithmetic: each nibble after correction is at most 12 (4-bit). The shift never carries out of the 20-bit scratch because 65535 needs only 5 digits.

## Timing
- Start accepted at edge E0: busy=1 from E0.
- Shifts occur at E1..E16 (for BIN_WIDTH=16).
- FIN occurs at E17: bcd_out, overflow and done=1 are updated and busy=0.
- done returns to 0 at E18.
- Latency: 17 cycles from the start edge to valid output.
- Back-to-back: start held high during the done cycle is accepted at E18. Maximum rate is one conversion per 18 cycles.
- General latency: BIN_WIDTH+1 cycles.
- Reset mid-conversion:
  - Conversion aborts immediately, no done pulse, outputs return to reset values.
  - After reset release, the first edge with start=1 begins a fresh conversion.
- At 100 MHz a conversion takes 170 ns. This is negligible against the 1 s update period and 2.6 ms digit period of the display.

## Test plan
- After reset release: bin_in=0, pulse start
  - done exactly at E17 with bcd_out=16'h0000, overflow=0.
  - busy high for exactly 17 cycles.
- Sequential conversions:
  - 1234 -> bcd_out=16'h1234, overflow=0.
  - 9999 -> 16'h9999, overflow=0.
  - 10000 -> 16'h0000, overflow=1.
  - 65535 -> 16'h5535, overflow=1.
- Start abuse:
  - With start=1 held continuously and bin_in=42: conversions complete every 18 cycles, each giving bcd_out=16'h0042, with exactly one done pulse each.
  - Start pulsed at E5 of a running conversion: no effect on timing or result.
- Input change during conversion: capture 0x0BAD (2989), then change bin_in to 0xFFFF at E3 -> result 16'h2989, overflow=0.
- Reset mid-conversion:
  - Drive reset=0 asynchronously between E8 and E9 -> busy, done, bcd_out and overflow go to 0 without waiting for a clock edge.
  - After release, a new start with 7 -> 16'h0007.
- Output hold: after result 16'h1234, keep start=0 for 1000 cycles -> bcd_out stays 16'h1234 and done stays 0.

Source files
------------

// File: rtl/bin16_to_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Produces four packed BCD digits for the seven-segment display controller
// plus an overflow flag when the value needs a fifth (ten-thousands) digit.
module bin16_to_bcd_converter #(
  parameter int unsigned BIN_WIDTH = 16
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          bcd_out,
  output logic                 overflow
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  localparam logic [4:0] LAST_BIT = 5'(BIN_WIDTH - 1);

  logic [1:0]              state;
  logic [BIN_WIDTH-1:0]    shift_reg;
  logic [19:0]             scratch;
  logic [19:0]             scratch_adj;
  logic [4:0]              bit_cnt;
  logic [19+BIN_WIDTH:0]   next_pair;

  // Add-3 correction on every BCD nibble of 5 or more, then the combined left shift
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    next_pair = {scratch_adj, shift_reg} << 1;
  end

  // Handshake FSM: capture on start in IDLE, shift BIN_WIDTH times, publish in FIN
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, shift_reg} <= next_pair;
          bit_cnt              <= bit_cnt + 5'd1;
          if (bit_cnt == LAST_BIT) begin
            state <= FIN;
          end
        end
        FIN: begin
          bcd_out  <= scratch[15:0];
          overflow <= (scratch[19:16] != 4'd0);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin16_to_bcd_converter.sv
// Self-checking bench for bin16_to_bcd_converter: scoreboard of expected
// {overflow, bcd} pushed at start acceptance, popped on each done pulse.
module tb_bin16_to_bcd_converter;

  logic        clock_100Mhz;
  logic        reset;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  logic [16:0] sb[$];
  int          passed;
  int          total;

  bin16_to_bcd_converter #(.BIN_WIDTH(16)) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .overflow    (overflow)
  );

  initial begin
    clock_100Mhz = 1'b0;
    forever #5 clock_100Mhz = ~clock_100Mhz;
  end

  // Reference: decimal digits via divide/modulo
  function automatic logic [16:0] model(input int unsigned v);
    logic [16:0] r;
    int unsigned t;
    t         = v % 10000;
    r[16]     = (v > 9999);
    r[15:12]  = 4'(t / 1000);
    r[11:8]   = 4'((t / 100) % 10);
    r[7:4]    = 4'((t / 10) % 10);
    r[3:0]    = 4'(t % 10);
    return r;
  endfunction

  // Request one conversion; returns at the negedge after the accepting edge E0
  task automatic start_conv(input logic [15:0] v);
    @(negedge clock_100Mhz);
    bin_in = v;
    start  = 1'b1;
    @(posedge clock_100Mhz);
    sb.push_back(model(v));
    @(negedge clock_100Mhz);
    start = 1'b0;
  endtask

  // Count negedges until done is seen (bounded); n is the number of negedges waited
  task automatic wait_done(output bit found, output int n, output int busy_cnt);
    found    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (!found && n < 60) begin
      @(negedge clock_100Mhz);
      n++;
      if (busy) busy_cnt++;
      if (done) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #23;
    total++;
    if ({busy, done, overflow, bcd_out} !== 19'd0) begin
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h, expected all 0",
               busy, done, overflow, bcd_out);
    end else passed++;
    @(negedge clock_100Mhz);
    reset = 1'b1;
  endtask

  task automatic test_zero_timing();
    bit found; int n; int bc; logic [16:0] exp;
    start_conv(16'd0);
    total++;
    if (busy !== 1'b1) $display("FAIL zero_busy_e0: got %b, expected 1", busy);
    else passed++;
    wait_done(found, n, bc);
    exp = sb.pop_front();
    total++;
    if (!found || n != 17) $display("FAIL zero_done_time: got found=%0d n=%0d, expected done at E17 (n=17)", found, n);
    else passed++;
    total++;
    if ({overflow, bcd_out} !== exp) $display("FAIL zero_result: got %h, expected %h", {overflow, bcd_out}, exp);
    else passed++;
    total++;
    if (bc != 16 || busy !== 1'b0) $display("FAIL zero_busy_len: got %0d busy cycles after E0 and busy=%b at done, expected 16 and 0", bc, busy);
    else passed++;
    @(negedge clock_100Mhz);
    total++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse: got done=%b at E18, expected 0", done);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] vals [4];
    bit found; int n; int bc; logic [16:0] exp;
    vals = '{16'd1234, 16'd9999, 16'd10000, 16'd65535};
    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done(found, n, bc);
      exp = sb.pop_front();
      total++;
      if (!found || {overflow, bcd_out} !== exp)
        $display("FAIL seq_%0d: found=%0d got ovf=%b bcd=%h, expected ovf=%b bcd=%h",
                 vals[i], found, overflow, bcd_out, exp[16], exp[15:0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit found; int n; int bc; logic [16:0] exp;
    @(negedge clock_100Mhz);
    bin_in = 16'd42;
    start  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(42));
      wait_done(found, n, bc);
      exp = sb.pop_front();
      total++;
      if (!found || n != 18 || {overflow, bcd_out} !== exp)
        $display("FAIL b2b_%0d: found=%0d interval=%0d bcd=%h ovf=%b, expected interval 18 bcd=%h ovf=%b",
                 k, found, n, bcd_out, overflow, exp[15:0], exp[16]);
      else passed++;
    end
    start = 1'b0;
    @(negedge clock_100Mhz);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_stop: got busy=%b done=%b, expected 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_start_pulse_midway();
    bit found; int n; int bc; logic [16:0] exp;
    start_conv(16'd4321);
    repeat (4) @(negedge clock_100Mhz);
    start  = 1'b1;
    bin_in = 16'd1111;
    @(negedge clock_100Mhz);
    start = 1'b0;
    wait_done(found, n, bc);
    exp = sb.pop_front();
    total++;
    if (!found || n != 12 || {overflow, bcd_out} !== exp)
      $display("FAIL start_e5: found=%0d n=%0d bcd=%h ovf=%b, expected n=12 bcd=%h ovf=%b",
               found, n, bcd_out, overflow, exp[15:0], exp[16]);
    else passed++;
    repeat (20) @(negedge clock_100Mhz);
    total++;
    if (busy !== 1'b0) $display("FAIL start_e5_queued: got busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_input_change();
    bit found; int n; int bc; logic [16:0] exp;
    start_conv(16'h0BAD);
    repeat (2) @(negedge clock_100Mhz);
    bin_in = 16'hFFFF;
    wait_done(found, n, bc);
    exp = sb.pop_front();
    total++;
    if (!found || n != 15 || {overflow, bcd_out} !== exp)
      $display("FAIL input_change: found=%0d n=%0d bcd=%h ovf=%b, expected n=15 bcd=%h ovf=%b",
               found, n, bcd_out, overflow, exp[15:0], exp[16]);
    else passed++;
  endtask

  task automatic test_hold();
    bit found; int n; int bc; logic [16:0] exp; bit bad;
    start_conv(16'd1234);
    wait_done(found, n, bc);
    exp = sb.pop_front();
    total++;
    if (!found || {overflow, bcd_out} !== exp)
      $display("FAIL hold_setup: found=%0d got %h, expected %h", found, {overflow, bcd_out}, exp);
    else passed++;
    bad = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock_100Mhz);
      if (!bad && (bcd_out !== 16'h1234 || done !== 1'b0)) begin
        bad = 1'b1;
        $display("FAIL hold: cycle %0d got bcd=%h done=%b, expected bcd=1234 done=0", c, bcd_out, done);
      end
    end
    total++;
    if (!bad) passed++;
  endtask

  task automatic test_reset_mid();
    bit found; int n; int bc; logic [16:0] exp; bit saw_done;
    start_conv(16'd9999);
    repeat (8) @(negedge clock_100Mhz);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy, done, overflow, bcd_out} !== 19'd0)
      $display("FAIL reset_mid_async: got busy=%b done=%b ovf=%b bcd=%h, expected all 0",
               busy, done, overflow, bcd_out);
    else passed++;
    void'(sb.pop_front());
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock_100Mhz);
      if (done || busy) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clock_100Mhz);
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done) $display("FAIL reset_mid_abort: got activity after abort, expected none");
    else passed++;
    start_conv(16'd7);
    wait_done(found, n, bc);
    exp = sb.pop_front();
    total++;
    if (!found || n != 17 || {overflow, bcd_out} !== exp)
      $display("FAIL reset_mid_restart: found=%0d n=%0d bcd=%h ovf=%b, expected n=17 bcd=%h ovf=%b",
               found, n, bcd_out, overflow, exp[15:0], exp[16]);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_zero_timing();
    test_sequential();
    test_back_to_back();
    test_start_pulse_midway();
    test_input_change();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
